// File: rtl/txc_pkg.sv
// Shared constants for the TXC/JV001-family protection-and-banking core.
// Register indices, CPU address decode, save-state indices, reset values.
// Pure declarations; no logic, no timing, no flow control.
package txc_pkg;

  // Chip register index, taken from cpu_addr[1:0] of a decoded $4100 write.
  localparam logic [1:0] REG_ACC   = 2'd0;
  localparam logic [1:0] REG_INV   = 2'd1;
  localparam logic [1:0] REG_STAGE = 2'd2;
  localparam logic [1:0] REG_MODE  = 2'd3;

  // $4100-$4103 decode: bits outside the mask are don't-care mirrors.
  localparam logic [15:0] ADDR_MASK = 16'hE103;
  localparam logic [15:0] ADDR_BASE = 16'h4100;

  // Save-state register indices.
  localparam logic [7:0] SS_ACC    = 8'd0;
  localparam logic [7:0] SS_INV    = 8'd1;
  localparam logic [7:0] SS_STAGE  = 8'd2;
  localparam logic [7:0] SS_MODE   = 8'd3;
  localparam logic [7:0] SS_OUT    = 8'd4;
  localparam logic [7:0] SS_MAPNUM = 8'd127;

  // Banks come up as all ones so the fixed last bank is mapped after reset.
  localparam logic [5:0] OUT_RST = 6'h3F;

  // One-hot write enable for a chip register index.
  function automatic logic [3:0] reg_onehot(input logic [1:0] n);
    return 4'b0001 << n;
  endfunction

endpackage

// File: rtl/txc_acc.sv
// Accumulator/inverter/staging/mode block of the TXC chip, plus inverted acc.
// Latency: updates on the falling m2 edge that samples the write; o_acc_x is combinational.
// No backpressure: every enabled write is taken in the cycle it is presented.
module txc_acc
  import txc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_wr_en,
  input  logic [3:0] i_ss_we,
  input  logic [5:0] i_d6,
  input  logic       i_d1,
  output logic [5:0] o_acc,
  output logic       o_inv,
  output logic [5:0] o_stage,
  output logic       o_mode,
  output logic [5:0] o_acc_x
);

  logic [5:0] r_acc;
  logic       r_inv;
  logic [5:0] r_stage;
  logic       r_mode;

  // Save-state restore beats reset, reset beats CPU register writes.
  always_ff @(negedge i_clk) begin
    if (|i_ss_we) begin
      if (i_ss_we[REG_ACC])   r_acc   <= i_d6;
      if (i_ss_we[REG_INV])   r_inv   <= i_d1;
      if (i_ss_we[REG_STAGE]) r_stage <= i_d6;
      if (i_ss_we[REG_MODE])  r_mode  <= i_d1;
    end else if (i_rst) begin
      r_acc   <= 6'd0;
      r_inv   <= 1'b0;
      r_stage <= 6'd0;
      r_mode  <= 1'b0;
    end else begin
      if (i_wr_en[REG_ACC])   r_acc   <= r_mode ? r_acc + 6'd1 : r_stage ^ {6{r_inv}};
      if (i_wr_en[REG_INV])   r_inv   <= i_d1;
      if (i_wr_en[REG_STAGE]) r_stage <= i_d6;
      if (i_wr_en[REG_MODE])  r_mode  <= i_d1;
    end
  end

  assign o_acc   = r_acc;
  assign o_inv   = r_inv;
  assign o_stage = r_stage;
  assign o_mode  = r_mode;
  assign o_acc_x = r_acc ^ {6{r_inv}};

endmodule

// File: rtl/map_txc_core.sv
// TXC/JV001 core: $4100 decode, output latch, PRG/CHR bank slicing, readback, save-state.
// Latency: state and banks update on the falling m2 edge of the write; readback/ss_rdat combinational.
// No backpressure: CPU and save-state accesses are accepted every cycle.
module map_txc_core
  import txc_pkg::*;
#(
  parameter int         PRG_BITS    = 2,
  parameter int         CHR_BITS    = 4,
  parameter bit         CHR_REVERSE = 1'b1,
  parameter logic [7:0] RD_MASK     = 8'h3F,
  parameter logic [7:0] RD_FILL     = 8'h40,
  parameter logic [7:0] MAP_NUM     = 8'd27
) (
  input  logic                m2,
  input  logic                map_rst,
  input  logic [15:0]         cpu_addr,
  input  logic [7:0]          cpu_dat,
  input  logic                cpu_rw,
  input  logic                cpu_ce,
  input  logic                ss_act,
  input  logic                ss_we,
  input  logic [7:0]          ss_addr,
  output logic [PRG_BITS-1:0] prg_bank,
  output logic [CHR_BITS-1:0] chr_bank,
  output logic                map_cpu_oe,
  output logic [7:0]          map_cpu_dout,
  output logic [7:0]          ss_rdat
);

  logic [15:0] w_dec;
  logic        w_hit;
  logic [3:0]  w_wr_en;
  logic        w_ss_en;
  logic [3:0]  w_ss_we;
  logic        w_ss_out;
  logic        w_rst;
  logic        w_out_wr;
  logic [5:0]  w_d6;
  logic [5:0]  w_acc;
  logic        w_inv;
  logic [5:0]  w_stage;
  logic        w_mode;
  logic [5:0]  w_acc_x;
  logic [3:0]  w_rev;
  logic [5:0]  r_out;

  // Any address in the $4100 alias set selects a chip register by its low two bits.
  assign w_dec    = cpu_addr & ADDR_MASK;
  assign w_hit    = (w_dec & ~16'h0003) == ADDR_BASE;
  assign w_wr_en  = (!ss_act && !cpu_rw && w_hit) ? reg_onehot(w_dec[1:0]) : 4'b0000;
  assign w_out_wr = !ss_act && !cpu_rw && !cpu_ce;

  // Save-state mode freezes normal decode and masks reset.
  assign w_rst      = map_rst && !ss_act;
  assign w_ss_en    = ss_act && ss_we;
  assign w_ss_we[0] = w_ss_en && (ss_addr == SS_ACC);
  assign w_ss_we[1] = w_ss_en && (ss_addr == SS_INV);
  assign w_ss_we[2] = w_ss_en && (ss_addr == SS_STAGE);
  assign w_ss_we[3] = w_ss_en && (ss_addr == SS_MODE);
  assign w_ss_out   = w_ss_en && (ss_addr == SS_OUT);
  assign w_d6       = 6'(cpu_dat & 8'h3F);

  txc_acc u_acc (
    .i_clk   (m2),
    .i_rst   (w_rst),
    .i_wr_en (w_wr_en),
    .i_ss_we (w_ss_we),
    .i_d6    (w_d6),
    .i_d1    (cpu_dat[0]),
    .o_acc   (w_acc),
    .o_inv   (w_inv),
    .o_stage (w_stage),
    .o_mode  (w_mode),
    .o_acc_x (w_acc_x)
  );

  // Output latch: a ROM-space write captures the inverted accumulator.
  always_ff @(negedge m2) begin
    if (w_ss_out) begin
      r_out <= w_d6;
    end else if (w_rst) begin
      r_out <= OUT_RST;
    end else if (w_out_wr) begin
      r_out <= w_acc_x;
    end
  end

  // Mapper 172 boards wire CHR lines in reverse order.
  assign w_rev    = {r_out[0], r_out[1], r_out[2], r_out[3]};
  assign prg_bank = r_out[4 +: PRG_BITS];
  assign chr_bank = CHR_REVERSE ? w_rev[CHR_BITS-1:0] : r_out[CHR_BITS-1:0];

  assign map_cpu_oe   = cpu_rw && m2 && w_hit;
  assign map_cpu_dout = ({2'b00, w_acc_x} & RD_MASK) | RD_FILL;

  // Save-state readback of the indexed field, LSB-aligned.
  always_comb begin
    ss_rdat = 8'hFF;
    case (ss_addr)
      SS_ACC:    ss_rdat = {2'b00, w_acc};
      SS_INV:    ss_rdat = {7'd0, w_inv};
      SS_STAGE:  ss_rdat = {2'b00, w_stage};
      SS_MODE:   ss_rdat = {7'd0, w_mode};
      SS_OUT:    ss_rdat = {2'b00, r_out};
      SS_MAPNUM: ss_rdat = MAP_NUM;
      default:   ss_rdat = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_map_txc_core.sv
// Directed bench for map_txc_core with default parameters (mapper 172 wiring).
// Inputs change 1 ns after a falling m2 edge or while m2 is high; outputs sampled away from edges.
// Expected values are hand-computed constants.
module tb_map_txc_core;

  logic        m2;
  logic        map_rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        cpu_rw;
  logic        cpu_ce;
  logic        ss_act;
  logic        ss_we;
  logic [7:0]  ss_addr;
  logic [1:0]  prg_bank;
  logic [3:0]  chr_bank;
  logic        map_cpu_oe;
  logic [7:0]  map_cpu_dout;
  logic [7:0]  ss_rdat;

  int total = 0;
  int bad   = 0;

  map_txc_core dut (
    .m2           (m2),
    .map_rst      (map_rst),
    .cpu_addr     (cpu_addr),
    .cpu_dat      (cpu_dat),
    .cpu_rw       (cpu_rw),
    .cpu_ce       (cpu_ce),
    .ss_act       (ss_act),
    .ss_we        (ss_we),
    .ss_addr      (ss_addr),
    .prg_bank     (prg_bank),
    .chr_bank     (chr_bank),
    .map_cpu_oe   (map_cpu_oe),
    .map_cpu_dout (map_cpu_dout),
    .ss_rdat      (ss_rdat)
  );

  initial m2 = 1'b0;
  always #10 m2 = ~m2;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cpu_addr = 16'h0000;
    cpu_rw   = 1'b1;
    cpu_ce   = 1'b1;
    ss_act   = 1'b0;
    ss_we    = 1'b0;
    map_rst  = 1'b0;
  endtask

  // One CPU write cycle, sampled on the next falling m2 edge.
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_dat  = d;
    cpu_rw   = 1'b0;
    cpu_ce   = ~a[15];
    @(negedge m2);
    #1;
    idle();
  endtask

  // CPU read cycle: check readback while m2 is high.
  task automatic rd(input string tag, input logic [15:0] a, input logic exp_oe, input logic [7:0] exp_d);
    cpu_addr = a;
    cpu_rw   = 1'b1;
    cpu_ce   = ~a[15];
    @(posedge m2);
    #1;
    chk({tag, "_oe"}, {7'd0, map_cpu_oe}, {7'd0, exp_oe});
    chk({tag, "_dout"}, map_cpu_dout, exp_d);
    @(negedge m2);
    #1;
    idle();
  endtask

  task automatic st(input string tag, input logic [7:0] idx, input logic [7:0] exp);
    ss_addr = idx;
    #1;
    chk(tag, ss_rdat, exp);
  endtask

  initial begin
    idle();
    cpu_dat = 8'h00;
    ss_addr = 8'h00;
    map_rst = 1'b1;
    repeat (2) @(negedge m2);
    #1;
    idle();

    // Reset state
    chk("rst_prg", {6'd0, prg_bank}, 8'h03);
    chk("rst_chr", {4'd0, chr_bank}, 8'h0F);
    st("rst_acc", 8'd0, 8'h00);
    st("rst_out", 8'd4, 8'h3F);
    st("rst_mode", 8'd3, 8'h00);
    rd("rst_rd", 16'h4100, 1'b1, 8'h40);

    // Load mode with inversion: acc = 0x15 ^ 0x3F = 0x2A, readback 0x15|0x40
    wr(16'h4102, 8'h15);
    wr(16'h4101, 8'h01);
    wr(16'h4103, 8'h00);
    wr(16'h4100, 8'h00);
    st("load_acc", 8'd0, 8'h2A);
    rd("load_rd", 16'h4100, 1'b1, 8'h55);
    wr(16'h8000, 8'h00);
    st("latch_out", 8'd4, 8'h15);
    chk("latch_prg", {6'd0, prg_bank}, 8'h01);
    chk("latch_chr", {4'd0, chr_bank}, 8'h0A);

    // Increment mode wraps 63 -> 0
    wr(16'h4101, 8'h00);
    wr(16'h4102, 8'h3F);
    wr(16'h4100, 8'h00);
    st("pre_wrap_acc", 8'd0, 8'h3F);
    wr(16'h4103, 8'h01);
    wr(16'h4100, 8'h00);
    st("wrap_acc", 8'd0, 8'h00);
    rd("wrap_rd_inv0", 16'h4100, 1'b1, 8'h40);
    wr(16'h4101, 8'h01);
    rd("wrap_rd_inv1", 16'h4100, 1'b1, 8'h7F);

    // Load mode, acc already equals stage^inv: alias writes and reads leave state alone
    wr(16'h4103, 8'h00);
    wr(16'h4104, 8'h77);
    wr(16'h4180, 8'h77);
    wr(16'h4202, 8'h01);
    wr(16'h6103, 8'h01);
    rd("alias_rd4101", 16'h4101, 1'b1, 8'h7F);
    st("alias_acc", 8'd0, 8'h00);
    st("alias_stage", 8'd2, 8'h3F);
    st("alias_inv", 8'd1, 8'h01);
    st("alias_mode", 8'd3, 8'h00);
    st("alias_out", 8'd4, 8'h15);
    rd("oe_4500", 16'h4500, 1'b1, 8'h7F);
    rd("oe_4200", 16'h4200, 1'b0, 8'h7F);
    rd("oe_6100", 16'h6100, 1'b0, 8'h7F);
    cpu_addr = 16'h4100;
    cpu_rw   = 1'b1;
    #2;
    chk("oe_m2_low", {7'd0, map_cpu_oe}, 8'h00);
    idle();

    // Save-state restore wins over reset and over a concurrent ROM write
    ss_act   = 1'b1;
    ss_we    = 1'b1;
    ss_addr  = 8'd2;
    cpu_dat  = 8'h2A;
    map_rst  = 1'b1;
    cpu_addr = 16'h8000;
    cpu_rw   = 1'b0;
    cpu_ce   = 1'b0;
    @(negedge m2);
    #1;
    ss_we = 1'b0;
    @(negedge m2);
    #1;
    idle();
    ss_act = 1'b1;
    st("ss_stage", 8'd2, 8'h2A);
    st("ss_acc_kept", 8'd0, 8'h00);
    st("ss_inv_kept", 8'd1, 8'h01);
    st("ss_out_kept", 8'd4, 8'h15);
    st("ss_mapnum", 8'd127, 8'd27);
    st("ss_unused", 8'd9, 8'hFF);
    ss_we   = 1'b1;
    ss_addr = 8'd4;
    cpu_dat = 8'h0C;
    @(negedge m2);
    #1;
    idle();
    st("ss_out_rest", 8'd4, 8'h0C);
    chk("ss_prg", {6'd0, prg_bank}, 8'h00);
    chk("ss_chr", {4'd0, chr_bank}, 8'h03);

    // Reset in the same cycle as a ROM write: reset wins (write would give 0x00)
    wr(16'h4101, 8'h00);
    cpu_addr = 16'h8000;
    cpu_dat  = 8'h00;
    cpu_rw   = 1'b0;
    cpu_ce   = 1'b0;
    map_rst  = 1'b1;
    @(negedge m2);
    #1;
    idle();
    st("rstwr_out", 8'd4, 8'h3F);
    st("rstwr_stage", 8'd2, 8'h00);
    chk("rstwr_prg", {6'd0, prg_bank}, 8'h03);
    chk("rstwr_chr", {4'd0, chr_bank}, 8'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
